// File: rtl/mips_ctrl_regs_if.sv
// Datapath <-> control/state block bundle for the single-cycle MIPS core.
// master = datapath side, slave = mips_ctrl_regs.
interface mips_ctrl_regs_if #(parameter int WIDTH = 32);
  logic [5:0]       dcd_op, dcd_funct2;
  logic [4:0]       rs_num, rt_num, rd_num;
  logic [WIDTH-1:0] rd_data, pc;
  logic             halted;
  logic             IBE, DBE, Ov, BP, AdEL_inst, AdEL_data, AdES, CpU;
  logic [WIDTH-1:0] rs_data, rt_data;
  logic             ctrl_we, ctrl_Sys, ctrl_RI;
  logic [3:0]       alu__sel;
  logic             alu__src, mem_to_reg;
  logic [1:0]       ins_type;
  logic             imm_sign, is_shift;
  logic [2:0]       mem_read_bytes, mem_write_bytes;
  logic [3:0]       mem_write_en;
  logic             exception_halt, load_ex_regs, load_bva, load_bva_sel;
  logic [4:0]       cause;

  modport master (
    output dcd_op, dcd_funct2, rs_num, rt_num, rd_num, rd_data, pc, halted,
           IBE, DBE, Ov, BP, AdEL_inst, AdEL_data, AdES, CpU,
    input  rs_data, rt_data, ctrl_we, ctrl_Sys, ctrl_RI, alu__sel, alu__src,
           mem_to_reg, ins_type, imm_sign, is_shift, mem_read_bytes,
           mem_write_bytes, mem_write_en, exception_halt, load_ex_regs,
           load_bva, load_bva_sel, cause
  );

  modport slave (
    input  dcd_op, dcd_funct2, rs_num, rt_num, rd_num, rd_data, pc, halted,
           IBE, DBE, Ov, BP, AdEL_inst, AdEL_data, AdES, CpU,
    output rs_data, rt_data, ctrl_we, ctrl_Sys, ctrl_RI, alu__sel, alu__src,
           mem_to_reg, ins_type, imm_sign, is_shift, mem_read_bytes,
           mem_write_bytes, mem_write_en, exception_halt, load_ex_regs,
           load_bva, load_bva_sel, cause
  );
endinterface

// File: rtl/mips_ctrl_regs.sv
// Decoder, 32x32 register file and exception/cause logic of the single-cycle MIPS core.
module mips_ctrl_regs #(
  parameter int NREG  = 32,
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_b,
  mips_ctrl_regs_if.slave bus
);
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_ADDU = 4'd1, ALU_SUB = 4'd2, ALU_SUBU = 4'd3,
                         ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_SRL = 4'd7,
                         ALU_SRA = 4'd8, ALU_SLL = 4'd9;
  localparam logic [1:0] T_R = 2'd0, T_I = 2'd1, T_J = 2'd2;

  always_comb begin
    bus.ctrl_we         = 1'b0;
    bus.ctrl_Sys        = 1'b0;
    bus.ctrl_RI         = 1'b0;
    bus.alu__sel        = ALU_ADD;
    bus.alu__src        = 1'b0;
    bus.mem_to_reg      = 1'b0;
    bus.ins_type        = T_R;
    bus.imm_sign        = 1'b0;
    bus.is_shift        = 1'b0;
    bus.mem_read_bytes  = 3'd0;
    bus.mem_write_bytes = 3'd0;
    bus.mem_write_en    = 4'b0000;
    case (bus.dcd_op)
      6'h00: case (bus.dcd_funct2)
        6'h20: begin bus.alu__sel = ALU_ADD;  bus.ctrl_we = 1'b1; end
        6'h21: begin bus.alu__sel = ALU_ADDU; bus.ctrl_we = 1'b1; end
        6'h22: begin bus.alu__sel = ALU_SUB;  bus.ctrl_we = 1'b1; end
        6'h23: begin bus.alu__sel = ALU_SUBU; bus.ctrl_we = 1'b1; end
        6'h24: begin bus.alu__sel = ALU_AND;  bus.ctrl_we = 1'b1; end
        6'h25: begin bus.alu__sel = ALU_OR;   bus.ctrl_we = 1'b1; end
        6'h26: begin bus.alu__sel = ALU_XOR;  bus.ctrl_we = 1'b1; end
        6'h00: begin bus.alu__sel = ALU_SLL; bus.is_shift = 1'b1; bus.ctrl_we = 1'b1; end
        6'h02: begin bus.alu__sel = ALU_SRL; bus.is_shift = 1'b1; bus.ctrl_we = 1'b1; end
        6'h03: begin bus.alu__sel = ALU_SRA; bus.is_shift = 1'b1; bus.ctrl_we = 1'b1; end
        6'h0C: bus.ctrl_Sys = 1'b1;
        default: bus.ctrl_RI = 1'b1;
      endcase
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: begin
        bus.ins_type = T_I;
        bus.ctrl_we  = 1'b1;
        bus.alu__src = 1'b1;
        case (bus.dcd_op)
          6'h08:   begin bus.alu__sel = ALU_ADD;  bus.imm_sign = 1'b1; end
          6'h09:   begin bus.alu__sel = ALU_ADDU; bus.imm_sign = 1'b1; end
          6'h0C:   bus.alu__sel = ALU_AND;
          6'h0D:   bus.alu__sel = ALU_OR;
          default: bus.alu__sel = ALU_XOR;
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        bus.ins_type   = T_I;
        bus.ctrl_we    = 1'b1;
        bus.alu__src   = 1'b1;
        bus.imm_sign   = 1'b1;
        bus.mem_to_reg = 1'b1;
        case (bus.dcd_op[1:0])
          2'd0:    bus.mem_read_bytes = 3'd1;
          2'd1:    bus.mem_read_bytes = 3'd2;
          default: bus.mem_read_bytes = 3'd4;
        endcase
      end
      6'h28, 6'h29, 6'h2B: begin
        bus.ins_type = T_I;
        bus.alu__src = 1'b1;
        bus.imm_sign = 1'b1;
        case (bus.dcd_op[1:0])
          2'd0:    begin bus.mem_write_bytes = 3'd1; bus.mem_write_en = 4'b0001; end
          2'd1:    begin bus.mem_write_bytes = 3'd2; bus.mem_write_en = 4'b0011; end
          default: begin bus.mem_write_bytes = 3'd4; bus.mem_write_en = 4'b1111; end
        endcase
      end
      6'h02: bus.ins_type = T_J;
      6'h03: begin bus.ins_type = T_J; bus.ctrl_we = 1'b1; end
      default: bus.ctrl_RI = 1'b1;
    endcase
  end

  // Register file: r0 is never written, so it reads back as zero without a mux.
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (bus.ctrl_we && bus.rd_num != 5'd0) regs_d[bus.rd_num] = bus.rd_data;
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.rs_data = regs_q[bus.rs_num];
  assign bus.rt_data = regs_q[bus.rt_num];

  logic       exc_any, bva_c, bva_sel_c;
  logic [4:0] cause_c;
  logic       exc_halt_q, exc_halt_d;

  always_comb begin
    exc_any   = 1'b1;
    bva_c     = 1'b0;
    bva_sel_c = 1'b0;
    cause_c   = 5'd0;
    if      (bus.AdEL_inst) begin cause_c = 5'd4; bva_c = 1'b1; end
    else if (bus.IBE)       cause_c = 5'd6;
    else if (bus.ctrl_RI)   cause_c = 5'd10;
    else if (bus.CpU)       cause_c = 5'd11;
    else if (bus.Ov)        cause_c = 5'd12;
    else if (bus.BP)        cause_c = 5'd9;
    else if (bus.AdEL_data) begin cause_c = 5'd4; bva_c = 1'b1; bva_sel_c = 1'b1; end
    else if (bus.AdES)      begin cause_c = 5'd5; bva_c = 1'b1; bva_sel_c = 1'b1; end
    else if (bus.DBE)       cause_c = 5'd7;
    else                    exc_any = 1'b0;
    exc_halt_d = exc_halt_q | exc_any;
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) exc_halt_q <= 1'b0;
    else       exc_halt_q <= exc_halt_d;
  end

  // Once halted, the first exception's EPC/Cause/BadVAddr must not be overwritten.
  assign bus.exception_halt = exc_halt_q;
  assign bus.load_ex_regs   = exc_any & ~exc_halt_q;
  assign bus.load_bva       = bva_c & ~exc_halt_q;
  assign bus.load_bva_sel   = bva_sel_c;
  assign bus.cause          = cause_c;

  // Register dump on halt is a simulation nicety with no hardware effect.
  logic unused_inputs;
  assign unused_inputs = bus.halted ^ (^bus.pc);
endmodule

// File: tb/tb_mips_ctrl_regs.sv
// Scoreboard bench for mips_ctrl_regs: a behavioural model predicts every cycle's outputs,
// a negedge monitor pops and compares.
module tb_mips_ctrl_regs;
  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  mips_ctrl_regs_if #(.WIDTH(32)) bus ();
  mips_ctrl_regs #(.NREG(32), .WIDTH(32)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

  typedef struct {
    logic [31:0] rs, rt;
    logic        we, sys, ri;
    logic [3:0]  alu;
    logic        src, m2r;
    logic [1:0]  typ;
    logic        imm, sh;
    logic [2:0]  rb, wb;
    logic [3:0]  wen;
    logic        halt, lex, lbva, lbsel;
    logic [4:0]  cause;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mregs [32];
  bit          mhalt = 1'b0;

  logic [5:0] vops [16] = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h20, 6'h21,
                            6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h02, 6'h03};
  logic [5:0] vfns [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                            6'h00, 6'h02, 6'h03, 6'h0C};

  // Priority order, highest first: AdEL_inst, IBE, RI, CpU, Ov, BP, AdEL_data, AdES, DBE
  logic [4:0] pcode [9] = '{5'd4, 5'd6, 5'd10, 5'd11, 5'd12, 5'd9, 5'd4, 5'd5, 5'd7};
  bit         pbva  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  bit         psel  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] size_of(logic [1:0] lo);
    return (lo == 2'd0) ? 3'd1 : (lo == 2'd1) ? 3'd2 : 3'd4;
  endfunction

  function automatic exp_t decode(logic [5:0] op, logic [5:0] fn);
    exp_t e = '{default: '0};
    case (op)
      6'h00: begin
        if (fn >= 6'h20 && fn <= 6'h26) begin e.we = 1; e.alu = 4'(fn - 6'h20); end
        else if (fn == 6'h00) begin e.we = 1; e.sh = 1; e.alu = 4'd9; end
        else if (fn == 6'h02) begin e.we = 1; e.sh = 1; e.alu = 4'd7; end
        else if (fn == 6'h03) begin e.we = 1; e.sh = 1; e.alu = 4'd8; end
        else if (fn == 6'h0C) e.sys = 1;
        else e.ri = 1;
      end
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: begin
        e.typ = 2'd1; e.we = 1; e.src = 1;
        e.imm = (op < 6'h0C);
        e.alu = (op == 6'h08) ? 4'd0 : (op == 6'h09) ? 4'd1 : 4'(op - 6'h0C + 6'd4);
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        e.typ = 2'd1; e.we = 1; e.src = 1; e.imm = 1; e.m2r = 1; e.rb = size_of(op[1:0]);
      end
      6'h28, 6'h29, 6'h2B: begin
        e.typ = 2'd1; e.src = 1; e.imm = 1; e.wb = size_of(op[1:0]);
        e.wen = 4'((1 << e.wb) - 1);
      end
      6'h02, 6'h03: begin e.typ = 2'd2; e.we = op[0]; end
      default: e.ri = 1;
    endcase
    return e;
  endfunction

  // exc bits: [7]AdEL_inst [6]IBE [5]CpU [4]Ov [3]BP [2]AdEL_data [1]AdES [0]DBE
  task automatic drive(bit r, logic [5:0] op, logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                       logic [4:0] rd, logic [31:0] d, logic [7:0] exc);
    exp_t e;
    bit   src [9];
    bit   any;
    rst_b = r;
    bus.dcd_op = op; bus.dcd_funct2 = fn;
    bus.rs_num = rs; bus.rt_num = rt; bus.rd_num = rd; bus.rd_data = d;
    bus.pc = $urandom; bus.halted = 1'($urandom);
    {bus.AdEL_inst, bus.IBE, bus.CpU, bus.Ov, bus.BP, bus.AdEL_data, bus.AdES, bus.DBE} = exc;
    if (r) begin
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      mhalt = 1'b0;
    end
    e = decode(op, fn);
    e.rs = mregs[rs];
    e.rt = mregs[rt];
    src = '{exc[7], exc[6], e.ri, exc[5], exc[4], exc[3], exc[2], exc[1], exc[0]};
    any = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (src[i] && !any) begin
        any = 1'b1; e.cause = pcode[i]; e.lbva = pbva[i]; e.lbsel = psel[i];
      end
    end
    e.halt = mhalt;
    e.lex  = any & !mhalt;
    e.lbva = e.lbva & !mhalt;
    sb.push_back(e);
    @(posedge clk);
    if (!r) begin
      if (e.we && rd != 5'd0) mregs[rd] = d;
      if (any) mhalt = 1'b1;
    end
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rs_data", bus.rs_data, e.rs);
        chk("rt_data", bus.rt_data, e.rt);
        chk("ctrl_we", 32'(bus.ctrl_we), 32'(e.we));
        chk("ctrl_Sys", 32'(bus.ctrl_Sys), 32'(e.sys));
        chk("ctrl_RI", 32'(bus.ctrl_RI), 32'(e.ri));
        chk("alu__sel", 32'(bus.alu__sel), 32'(e.alu));
        chk("alu__src", 32'(bus.alu__src), 32'(e.src));
        chk("mem_to_reg", 32'(bus.mem_to_reg), 32'(e.m2r));
        chk("ins_type", 32'(bus.ins_type), 32'(e.typ));
        chk("imm_sign", 32'(bus.imm_sign), 32'(e.imm));
        chk("is_shift", 32'(bus.is_shift), 32'(e.sh));
        chk("mem_read_bytes", 32'(bus.mem_read_bytes), 32'(e.rb));
        chk("mem_write_bytes", 32'(bus.mem_write_bytes), 32'(e.wb));
        chk("mem_write_en", 32'(bus.mem_write_en), 32'(e.wen));
        chk("exception_halt", 32'(bus.exception_halt), 32'(e.halt));
        chk("load_ex_regs", 32'(bus.load_ex_regs), 32'(e.lex));
        chk("load_bva", 32'(bus.load_bva), 32'(e.lbva));
        chk("load_bva_sel", 32'(bus.load_bva_sel), 32'(e.lbsel));
        chk("cause", 32'(bus.cause), 32'(e.cause));
      end
    end
  end

  initial begin
    logic [5:0] op, fn;
    logic [7:0] exc;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    bus.dcd_op = 6'h2B; bus.dcd_funct2 = '0; bus.rs_num = '0; bus.rt_num = '0;
    bus.rd_num = '0; bus.rd_data = '0; bus.pc = '0; bus.halted = 1'b0;
    {bus.AdEL_inst, bus.IBE, bus.CpU, bus.Ov, bus.BP, bus.AdEL_data, bus.AdES, bus.DBE} = '0;
    @(posedge clk); #1;

    // Reset, then every register reads zero (SW writes nothing).
    drive(1, 6'h2B, 6'h00, 5'd0, 5'd31, 5'd0, 32'h0, 8'h00);
    for (int i = 0; i < 32; i++) drive(0, 6'h2B, 6'h00, 5'(i), 5'(31 - i), 5'd0, 32'h0, 8'h00);
    // r5 write/readback, r0 write ignored, same-cycle read sees old value.
    drive(0, 6'h09, 6'h00, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 8'h00);
    drive(0, 6'h2B, 6'h00, 5'd5, 5'd5, 5'd0, 32'h0, 8'h00);
    drive(0, 6'h09, 6'h00, 5'd0, 5'd0, 5'd0, 32'h1234, 8'h00);
    drive(0, 6'h2B, 6'h00, 5'd0, 5'd5, 5'd0, 32'h0, 8'h00);
    drive(0, 6'h00, 6'h22, 5'd5, 5'd0, 5'd7, 32'h5, 8'h00);
    drive(0, 6'h23, 6'h00, 5'd7, 5'd0, 5'd8, 32'h6, 8'h00);
    drive(0, 6'h2B, 6'h00, 5'd8, 5'd7, 5'd0, 32'h0, 8'h00);
    drive(0, 6'h00, 6'h0C, 5'd0, 5'd0, 5'd0, 32'h0, 8'h00);
    // RI -> cause 10, halt sticks until reset.
    drive(0, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 8'h00);
    drive(0, 6'h2B, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 8'h00);
    drive(0, 6'h2B, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 8'h90);
    drive(1, 6'h2B, 6'h00, 5'd5, 5'd0, 5'd0, 32'h0, 8'h00);
    // AdEL_inst outranks Ov.
    drive(0, 6'h2B, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 8'h90);
    drive(1, 6'h2B, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 8'h00);

    for (int n = 0; n < 1200; n++) begin
      op  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : vops[$urandom_range(0, 15)];
      fn  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : vfns[$urandom_range(0, 10)];
      exc = '0;
      for (int b = 0; b < 8; b++) exc[b] = ($urandom_range(0, 29) == 0);
      drive($urandom_range(0, 24) == 0, op, fn, 5'($urandom), 5'($urandom),
            5'($urandom), $urandom, exc);
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
